// File: rtl/data_memory_hs.sv
// Big-endian byte-addressable data RAM behind a valid/ready request/response
// handshake with a programmable number of wait states.
module data_memory_hs #(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

  state_t state;
  state_t state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;

  logic        we_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        c_we;
  logic [1:0]  c_size;
  logic        c_sgn;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;

  logic accept;
  logic commit;
  logic is_byte;
  logic is_half;
  logic is_word;
  logic misal;
  logic oor;
  logic err;

  logic [ADDR_W-3:0] idx;
  logic [1:0]  off;
  logic [31:0] word;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld;
  logic [3:0]  be;
  logic [31:0] wd;

  logic [3:0][7:0] mem [DEPTH];

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = (state == IDLE) && req_valid;

  // With zero wait states the commit happens on the accept edge,
  // so the live request is used instead of the latched copy.
  always_comb begin
    if (state == IDLE) begin
      c_we    = req_we;
      c_size  = req_size;
      c_sgn   = req_signed;
      c_addr  = req_addr;
      c_wdata = req_wdata;
    end else begin
      c_we    = we_q;
      c_size  = size_q;
      c_sgn   = sgn_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
    end
  end

  assign is_byte = (c_size == 2'b01);
  assign is_half = (c_size == 2'b10);
  assign is_word = !is_byte && !is_half;

  assign misal = (is_half && c_addr[0]) ||
                 (is_word && (c_addr[1:0] != 2'b00));

  if (ADDR_W < 32) begin : g_oor
    assign oor = |c_addr[31:ADDR_W];
  end else begin : g_no_oor
    assign oor = 1'b0;
  end

  assign err  = misal || oor;
  assign idx  = c_addr[ADDR_W-1:2];
  assign off  = c_addr[1:0];
  assign word = mem[idx];

  always_comb begin
    ld_b = word[31:24];
    unique case (off)
      2'b00: ld_b = word[31:24];
      2'b01: ld_b = word[23:16];
      2'b10: ld_b = word[15:8];
      2'b11: ld_b = word[7:0];
      default: ld_b = word[31:24];
    endcase
  end

  assign ld_h = off[1] ? word[15:0] : word[31:16];

  always_comb begin
    ld = word;
    be = 4'b0000;
    wd = c_wdata;
    unique case (1'b1)
      is_byte: begin
        ld = {{24{c_sgn & ld_b[7]}}, ld_b};
        be = 4'b1000 >> off;
        wd = {4{c_wdata[7:0]}};
      end
      is_half: begin
        ld = {{16{c_sgn & ld_h[15]}}, ld_h};
        be = off[1] ? 4'b0011 : 4'b1100;
        wd = {2{c_wdata[15:0]}};
      end
      is_word: begin
        ld = word;
        be = 4'b1111;
        wd = c_wdata;
      end
      default: ;
    endcase
  end

  // Gated by reset so an edge during reset can never write the array.
  assign commit = RST_N && (
    (accept && (WAIT_CYCLES == 0)) ||
    ((state == WAIT) && (cnt == 4'd0)));

  always_ff @(posedge CLK) begin
    if (commit && c_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i] <= wd[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else cnt_nxt = cnt - 4'd1;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      sgn_q     <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        sgn_q   <= req_signed;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (commit) begin
        rsp_err   <= err;
        rsp_rdata <= (c_we || err) ? 32'd0 : ld;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_hs.sv
// Scoreboard bench for data_memory_hs: byte-array reference model,
// randomized traffic, backpressure, reset mid-transaction, zero wait states.
module tb_data_memory_hs;

  localparam int AW = 20;
  localparam int WC = 1;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        z_req_valid = 1'b0;
  logic        z_req_ready;
  logic        z_req_we = 1'b0;
  logic [1:0]  z_req_size = 2'b00;
  logic        z_req_signed = 1'b0;
  logic [31:0] z_req_addr = 32'd0;
  logic [31:0] z_req_wdata = 32'd0;
  logic        z_rsp_valid;
  logic        z_rsp_ready = 1'b1;
  logic [31:0] z_rsp_rdata;
  logic        z_rsp_err;

  always #5 CLK = ~CLK;

  data_memory_hs #(.ADDR_W(AW), .WAIT_CYCLES(WC)) u_dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_memory_hs #(.ADDR_W(12), .WAIT_CYCLES(0)) u_dut0 (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_we(z_req_we), .req_size(z_req_size),
    .req_signed(z_req_signed), .req_addr(z_req_addr),
    .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  ref_mem [int unsigned];
  int          passed = 0;
  int          total = 0;
  int          cyc = 0;
  bit          stall = 1'b0;
  bit          seen = 1'b0;
  logic [31:0] prev_rd;
  logic        prev_err;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req_v);
    total++;
    if (act === req_v) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, req_v);
  endtask

  // Memory as a flat byte array; lowest address holds the most significant byte.
  function automatic void model(input bit we, input logic [1:0] size,
                                input bit sgn, input logic [31:0] a,
                                input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
    int n;
    logic [31:0] v;
    n  = (size == 2'b01) ? 1 : (size == 2'b10) ? 2 : 4;
    er = ((a % n) != 0) || (64'(a) >= (64'd1 << AW));
    rd = 32'd0;
    if (er) return;
    if (we) begin
      for (int i = 0; i < n; i++)
        ref_mem[a + i] = 8'(wd >> (8 * (n - 1 - i)));
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++)
        v = (v << 8) | 32'(ref_mem[a + i]);
      if (sgn && n < 4 && v[8*n-1])
        v = v | (32'hFFFF_FFFF << (8 * n));
      rd = v;
    end
  endfunction

  always @(posedge CLK) begin
    #1;
    rsp_ready = stall ? 1'b0 : ($urandom_range(3) != 0);
  end

  always @(negedge CLK) begin
    if (!RST_N) begin
      seen = 1'b0;
    end else if (rsp_valid) begin
      check("req_ready_in_resp", 32'(req_ready), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        if (!seen) begin
          check("latency", 32'(cyc), 32'(sb[0].cyc));
          seen = 1'b1;
        end else begin
          check("hold_rdata", rsp_rdata, prev_rd);
          check("hold_err", 32'(rsp_err), 32'(prev_err));
        end
        prev_rd  = rsp_rdata;
        prev_err = rsp_err;
        if (rsp_ready) begin
          check("rdata", rsp_rdata, sb[0].rdata);
          check("err", 32'(rsp_err), 32'(sb[0].err));
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input bit we, input logic [1:0] size, input bit sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit track = 1'b1, input bit lit = 1'b0,
                       input logic [31:0] lit_rd = 32'd0,
                       input bit lit_err = 1'b0);
    exp_t e;
    logic [31:0] rd;
    logic er;
    int t;
    t = 0;
    @(negedge CLK);
    while (!req_ready && t < 200) begin
      @(negedge CLK);
      t++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    if (track) begin
      model(we, size, sgn, addr, wdata, rd, er);
      e.rdata = lit ? lit_rd : rd;
      e.err   = lit ? lit_err : er;
      e.cyc   = cyc + 1 + WC;
      sb.push_back(e);
    end
    @(posedge CLK);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge CLK);
      t++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int t;
    repeat (3) @(negedge CLK);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    RST_N = 1'b1;

    for (int w = 0; w < 16; w++)
      issue(1'b1, 2'b00, 1'b0, 32'h100 + 32'(4 * w), $urandom);
    drain();

    issue(1, 2'b00, 0, 32'h100, 32'hA1B2C3D4, 1, 1, 32'h0, 0);
    issue(0, 2'b00, 0, 32'h100, 32'h0, 1, 1, 32'hA1B2C3D4, 0);
    issue(0, 2'b01, 0, 32'h101, 32'h0, 1, 1, 32'h000000B2, 0);
    issue(0, 2'b01, 1, 32'h100, 32'h0, 1, 1, 32'hFFFFFFA1, 0);
    issue(0, 2'b10, 1, 32'h102, 32'h0, 1, 1, 32'hFFFFC3D4, 0);
    issue(0, 2'b10, 0, 32'h100, 32'h0, 1, 1, 32'h0000A1B2, 0);
    issue(1, 2'b01, 0, 32'h103, 32'h55, 1, 1, 32'h0, 0);
    issue(1, 2'b10, 0, 32'h100, 32'h1234, 1, 1, 32'h0, 0);
    issue(0, 2'b00, 0, 32'h100, 32'h0, 1, 1, 32'h1234C355, 0);
    issue(0, 2'b00, 0, 32'h102, 32'h0, 1, 1, 32'h0, 1);
    issue(1, 2'b10, 0, 32'h101, 32'hBEEF, 1, 1, 32'h0, 1);
    issue(0, 2'b00, 0, 32'h100, 32'h0, 1, 1, 32'h1234C355, 0);
    issue(0, 2'b00, 0, 32'h00100000, 32'h0, 1, 1, 32'h0, 1);
    issue(1, 2'b00, 0, 32'h00100100, 32'hDEADBEEF, 1, 1, 32'h0, 1);
    issue(0, 2'b00, 0, 32'h100, 32'h0, 1, 1, 32'h1234C355, 0);
    drain();

    stall = 1'b1;
    issue(0, 2'b00, 0, 32'h100, 32'h0, 1, 1, 32'h1234C355, 0);
    t = 0;
    while (!rsp_valid && t < 20) begin
      @(negedge CLK);
      t++;
    end
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    repeat (5) @(negedge CLK);
    stall = 1'b0;
    drain();

    repeat (300) begin
      a = 32'h100 + 32'($urandom_range(63));
      if ($urandom_range(9) == 0)
        a = a | (32'h1 << $urandom_range(31, AW));
      issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
    end
    drain();

    issue(1, 2'b00, 0, 32'h104, 32'h0BADF00D, 0);
    RST_N = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_rdata", rsp_rdata, 32'd0);
    check("midrst_err", 32'(rsp_err), 32'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    issue(0, 2'b00, 0, 32'h104, 32'h0);
    drain();

    @(negedge CLK);
    z_req_we    = 1'b1;
    z_req_size  = 2'b00;
    z_req_addr  = 32'h200;
    z_req_wdata = 32'hCAFEF00D;
    z_req_valid = 1'b1;
    @(posedge CLK);
    #1;
    z_req_valid = 1'b0;
    check("w0_sw_valid", 32'(z_rsp_valid), 32'd1);
    check("w0_sw_err", 32'(z_rsp_err), 32'd0);
    check("w0_sw_rdata", z_rsp_rdata, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    check("w0_idle_ready", 32'(z_req_ready), 32'd1);
    z_req_we    = 1'b0;
    z_req_valid = 1'b1;
    @(posedge CLK);
    #1;
    z_req_valid = 1'b0;
    check("w0_lw_valid", 32'(z_rsp_valid), 32'd1);
    check("w0_lw_rdata", z_rsp_rdata, 32'hCAFEF00D);
    @(posedge CLK);
    #1;
    check("w0_done_valid", 32'(z_rsp_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
